// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline constants: FSM state codes, register-specifier width and
// the bundle of stage-control signals the sequencer drives.
package pipeline_sequencer_pkg;

    localparam int REG_ADDR_SZ = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// operand in ID. Register 0 is hardwired, so it never creates a dependency.
module hazard_detect #(
    parameter int REG_ADDR_SZ = pipeline_sequencer_pkg::REG_ADDR_SZ
) (
    input  logic                   id_ex_mem_to_reg_i,
    input  logic [REG_ADDR_SZ-1:0] id_ex_rt_i,
    input  logic [REG_ADDR_SZ-1:0] if_id_rs_i,
    input  logic [REG_ADDR_SZ-1:0] if_id_rt_i,
    output logic                   load_use_o
);

    assign load_use_o = id_ex_mem_to_reg_i
                     && (id_ex_rt_i != '0)
                     && ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Debug-controlled pipeline sequencer: free-run / single-step / halt-drain FSM
// producing stage enables, bubble flushes and an advanced-cycle counter.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int REG_ADDR_SZ  = pipeline_sequencer_pkg::REG_ADDR_SZ
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_ex_mem_halt,
    input  logic                   i_id_ex_mem_to_reg,
    input  logic [REG_ADDR_SZ-1:0] i_id_ex_rt,
    input  logic [REG_ADDR_SZ-1:0] i_if_id_rs,
    input  logic [REG_ADDR_SZ-1:0] i_if_id_rt,
    input  logic                   i_branch_taken,
    output logic                   o_pc_en,
    output logic                   o_if_id_en,
    output logic                   o_id_ex_en,
    output logic                   o_ex_mem_en,
    output logic                   o_mem_wb_en,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_flush,
    output logic                   o_halted,
    output logic [2:0]             o_state,
    output logic [31:0]            o_cycle_count
);

    import pipeline_sequencer_pkg::*;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    stage_ctrl_t       ctrl;
    logic              advance;
    logic              halted;
    logic              load_use;

    hazard_detect #(
        .REG_ADDR_SZ (REG_ADDR_SZ)
    ) u_hazard_detect (
        .id_ex_mem_to_reg_i (i_id_ex_mem_to_reg),
        .id_ex_rt_i         (i_id_ex_rt),
        .if_id_rs_i         (i_if_id_rs),
        .if_id_rt_i         (i_if_id_rt),
        .load_use_o         (load_use)
    );

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset, so every flop in this block samples i_reset only at the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ctrl        = '0;
        advance     = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_ex_mem_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                advance = 1'b1;
                if (i_ex_mem_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (!i_run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                advance = 1'b1;
                if (i_ex_mem_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                ctrl.mem_wb_en = 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load-use stall holds PC and IF/ID and bubbles EX; it also wins
        // over a taken-branch flush, since the branch re-resolves next cycle.
        if (advance) begin
            ctrl.pc_en       = !load_use;
            ctrl.if_id_en    = !load_use;
            ctrl.id_ex_en    = 1'b1;
            ctrl.ex_mem_en   = 1'b1;
            ctrl.mem_wb_en   = 1'b1;
            ctrl.if_id_flush = i_branch_taken && !load_use;
            ctrl.id_ex_flush = load_use;
        end

        cycle_cnt_d = (advance && ctrl.mem_wb_en) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    end

    assign o_pc_en       = ctrl.pc_en;
    assign o_if_id_en    = ctrl.if_id_en;
    assign o_id_ex_en    = ctrl.id_ex_en;
    assign o_ex_mem_en   = ctrl.ex_mem_en;
    assign o_mem_wb_en   = ctrl.mem_wb_en;
    assign o_if_id_flush = ctrl.if_id_flush;
    assign o_id_ex_flush = ctrl.id_ex_flush;
    assign o_halted      = halted;
    assign o_state       = state_q;
    assign o_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_pipeline_sequencer;

    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        i_reset, i_run, i_step, i_ex_mem_halt, i_id_ex_mem_to_reg, i_branch_taken;
    logic [4:0]  i_id_ex_rt, i_if_id_rs, i_if_id_rt;
    logic        o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
    logic        o_if_id_flush, o_id_ex_flush, o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .DRAIN_CYCLES (DC),
        .REG_ADDR_SZ  (5)
    ) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_run              (i_run),
        .i_step             (i_step),
        .i_ex_mem_halt      (i_ex_mem_halt),
        .i_id_ex_mem_to_reg (i_id_ex_mem_to_reg),
        .i_id_ex_rt         (i_id_ex_rt),
        .i_if_id_rs         (i_if_id_rs),
        .i_if_id_rt         (i_if_id_rt),
        .i_branch_taken     (i_branch_taken),
        .o_pc_en            (o_pc_en),
        .o_if_id_en         (o_if_id_en),
        .o_id_ex_en         (o_id_ex_en),
        .o_ex_mem_en        (o_ex_mem_en),
        .o_mem_wb_en        (o_mem_wb_en),
        .o_if_id_flush      (o_if_id_flush),
        .o_id_ex_flush      (o_id_ex_flush),
        .o_halted           (o_halted),
        .o_state            (o_state),
        .o_cycle_count      (o_cycle_count)
    );

    int          n_total = 0;
    int          n_bad   = 0;

    // Model: mode 0 idle, 1 run, 2 step, 3 drain, 4 halted; drain_left counts down.
    int          m_mode;
    int          m_drain_left;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, checks outputs mid-cycle, steps the model.
    task automatic cycle(input logic rst, input logic run, input logic step, input logic halt,
                         input logic mtr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br);
        logic       adv, hz;
        logic [7:0] exp_ctrl;
        i_reset = rst; i_run = run; i_step = step; i_ex_mem_halt = halt;
        i_id_ex_mem_to_reg = mtr; i_id_ex_rt = ex_rt; i_if_id_rs = rs; i_if_id_rt = rt;
        i_branch_taken = br;
        #4;
        adv = (m_mode == 1) || (m_mode == 2);
        hz  = mtr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
        exp_ctrl = {adv && !hz, adv && !hz, adv, adv, adv || (m_mode == 3),
                    adv && br && !hz, adv && hz, m_mode == 4};
        check("ctrl", {24'd0, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                       o_if_id_flush, o_id_ex_flush, o_halted}, {24'd0, exp_ctrl});
        check("state", {29'd0, o_state}, 32'(m_mode));
        check("count", o_cycle_count, m_cnt);
        if (rst) begin
            m_mode = 0;
            m_cnt  = 0;
        end else begin
            if (adv) m_cnt = m_cnt + 1;
            if (m_mode <= 2 && halt) begin
                m_mode       = 3;
                m_drain_left = DC;
            end else if (m_mode == 0) begin
                m_mode = run ? 1 : (step ? 2 : 0);
            end else if (m_mode == 1) begin
                m_mode = run ? 1 : 0;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 3) begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        i_reset = 1; i_run = 0; i_step = 0; i_ex_mem_halt = 0; i_id_ex_mem_to_reg = 0;
        i_id_ex_rt = 0; i_if_id_rs = 0; i_if_id_rt = 0; i_branch_taken = 0;
        m_mode = 0; m_drain_left = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a single step pulse.
        idle(0);
        cycle(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(0);
        check("step_count", o_cycle_count, 32'd1);

        // RUN with load-use on rt=5, then rt=0, then stall against a taken branch.
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0);
        cycle(0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 1, 5'd7, 5'd2, 5'd7, 1);
        cycle(0, 1, 0, 0, 0, 5'd7, 5'd2, 5'd7, 1);
        cycle(0, 1, 0, 0, 1, 5'd7, 5'd2, 5'd3, 1);

        // Halt from RUN: drain, then halted with run/step ignored.
        cycle(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("halted_state", {29'd0, o_state}, 32'd4);
        cycle(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);

        // Reset on the first DRAIN cycle aborts the drain.
        idle(1);
        cycle(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);
        check("abort_memwb", {31'd0, o_mem_wb_en}, 32'd0);
        idle(0);

        // Counter wrap: preload just below the top while idle.
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("wrap_zero", o_cycle_count, 32'd0);
        idle(0);

        // Random traffic with occasional halts and resets.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                  ($urandom % 50) == 0, $urandom % 2, 5'($urandom % 4),
                  5'($urandom % 4), 5'($urandom % 4), ($urandom % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The block SHALL take parameter DRAIN_CYCLES, default 2, the number of cycles MEM/WB stays enabled after a halt is detected.
REQ-002 The block SHALL take parameter REG_ADDR_SZ, default 5, the register-specifier width.
REQ-003 The block SHALL have these ports (clock and reset first):
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_run  in  1  debug level: free-run while high
- i_step  in  1  debug pulse: advance one cycle
- i_ex_mem_halt  in  1  halt bit leaving EX/MEM
- i_id_ex_mem_to_reg  in  1  load in EX
- i_id_ex_rt  in  REG_ADDR_SZ  load destination in EX
- i_if_id_rs, i_if_id_rt  in  REG_ADDR_SZ  sources in ID
- i_branch_taken  in  1  branch/jump resolved taken in ID
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1  stage enables
- o_if_id_flush, o_id_ex_flush  out  1  bubble insert
- o_halted  out  1  pipeline fully drained
- o_state  out  3  FSM state code
- o_cycle_count  out  32  advanced-cycle counter

Function
REQ-004 The FSM SHALL have states IDLE, RUN, STEP, DRAIN, HALTED; all outputs SHALL be combinational from state and inputs except o_cycle_count (registered).
REQ-005 IDLE: all enables and flushes 0; i_run=1 -> RUN; else i_step=1 -> STEP.
REQ-006 RUN: advance (REQ-008); i_run=0 -> IDLE at next edge.
REQ-007 STEP: advance for exactly one cycle, then IDLE regardless of i_step; i_step in RUN/STEP/DRAIN/HALTED SHALL be ignored.
REQ-008 Advance: all five enables 1, flushes 0, modified by REQ-009/010.
REQ-009 Load-use hazard = i_id_ex_mem_to_reg && (i_id_ex_rt==i_if_id_rs || i_id_ex_rt==i_if_id_rt) && i_id_ex_rt!=0; during advance it SHALL force o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1.
REQ-010 i_branch_taken during advance SHALL set o_if_id_flush=1; if a load-use hazard is present in the same cycle, the stall wins and o_if_id_flush SHALL be 0.
REQ-011 i_ex_mem_halt=1 while in IDLE, RUN or STEP SHALL take priority over run/step and move the FSM to DRAIN at the next edge; the current cycle still behaves per its state.
REQ-012 DRAIN: o_mem_wb_en=1, all other enables and flushes 0; the block SHALL remain exactly DRAIN_CYCLES cycles, then go to HALTED.
REQ-013 HALTED: all enables 0, o_halted=1; exit only by reset.
REQ-014 o_cycle_count SHALL increment by 1 on each edge where o_mem_wb_en=1 in RUN or STEP and SHALL wrap 0xFFFFFFFF -> 0.
REQ-015 State codes: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.

Reset
REQ-016 While i_reset=1 at an edge: state IDLE, drain counter 0, o_cycle_count 0. Outputs then equal the IDLE values: all enables 0, flushes 0, o_halted 0, o_state 0.
REQ-017 Reset mid-DRAIN or mid-STEP SHALL abort immediately with no residual enable pulse.

Structure
REQ-018 State codes and REG_ADDR_SZ SHALL live in the shared pipeline constants package/include.
REQ-019 Hazard detection SHALL be a sub-module hazard_detect (pure combinational) instantiated once.

Verification
REQ-020 Reset, then i_step pulse 1 cycle -> exactly one cycle with all enables 1, o_cycle_count=1, o_state back to 0.
REQ-021 RUN, load in EX with rt=5 and ID rs=5 -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1 for that cycle; with rt=0 -> no stall.
REQ-022 RUN, load-use and i_branch_taken together -> stall outputs asserted, o_if_id_flush=0.
REQ-023 RUN, i_ex_mem_halt=1 -> next 2 cycles only o_mem_wb_en=1, then o_halted=1 and state 4; i_run/i_step are then ignored.
REQ-024 Reset asserted on the first DRAIN cycle -> state 0 and all enables 0 on the next cycle.
REQ-025 Preload near wrap (run 2^32-1 advances, or force) -> o_cycle_count goes 0xFFFFFFFF -> 0.
